// File: rtl/uart_cmd_parser.sv
// Assembles 0x55-framed UART byte packets into SDRAM read/write commands on a valid/ready port.
// Define CMD_PARSER_CSUM_EN to require a trailing XOR checksum byte on every frame.
module uart_cmd_parser #(
    parameter int         ADDR_WIDTH  = 24,
    parameter int         DATA_WIDTH  = 16,
    parameter logic [7:0] HDR_BYTE    = 8'h55,
    parameter logic [7:0] OP_WR       = 8'hA5,
    parameter logic [7:0] OP_RD       = 8'h5A,
    parameter int         TIMEOUT_CYC = 1_000_000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  po_flag,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_wr,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int NA = ADDR_WIDTH / 8;
    localparam int ND = DATA_WIDTH / 8;
    localparam int CW = $clog2(((NA > ND) ? NA : ND) + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP,
        S_ADDR,
        S_DATA,
`ifdef CMD_PARSER_CSUM_EN
        S_CSUM,
`endif
        S_ISSUE
    } state_t;

    // State following the last address/data byte of a frame.
`ifdef CMD_PARSER_CSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_ISSUE;
`endif

    state_t        state, next_state;
    logic          err_set;
    logic [CW-1:0] byte_cnt;
    logic [TW-1:0] to_cnt;
    logic [7:0]    csum;
    logic          in_frame;
    logic          timeout;
    logic          last_addr;
    logic          last_data;

    assign in_frame  = (state != S_IDLE) && (state != S_ISSUE);
    assign timeout   = (to_cnt == TW'(TIMEOUT_CYC - 1));
    assign last_addr = (byte_cnt == CW'(NA - 1));
    assign last_data = (byte_cnt == CW'(ND - 1));
    assign cmd_valid = (state == S_ISSUE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        err_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (po_flag && rx_data == HDR_BYTE) next_state = S_OP;
            end
            S_OP: begin
                if (po_flag) begin
                    if (rx_data == OP_WR || rx_data == OP_RD) begin
                        next_state = S_ADDR;
                    end else begin
                        next_state = S_IDLE;
                        err_set    = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (po_flag && last_addr) next_state = cmd_wr ? S_DATA : S_TAIL;
            end
            S_DATA: begin
                if (po_flag && last_data) next_state = S_TAIL;
            end
`ifdef CMD_PARSER_CSUM_EN
            S_CSUM: begin
                if (po_flag) begin
                    if (rx_data == csum) begin
                        next_state = S_ISSUE;
                    end else begin
                        next_state = S_IDLE;
                        err_set    = 1'b1;
                    end
                end
            end
`endif
            S_ISSUE: begin
                // A byte arriving while a command waits is an overrun; the command stays.
                if (po_flag)   err_set    = 1'b1;
                if (cmd_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        if (in_frame && !po_flag && timeout) begin
            next_state = S_IDLE;
            err_set    = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cmd_wr    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            frame_err <= 1'b0;
            byte_cnt  <= '0;
            to_cnt    <= '0;
            csum      <= '0;
        end else begin
            frame_err <= err_set;
            if (po_flag || !in_frame) to_cnt <= '0;
            else if (!timeout)        to_cnt <= to_cnt + 1'b1;

            if (state == S_IDLE && next_state == S_OP) begin
                cmd_addr  <= '0;
                cmd_wdata <= '0;
                byte_cnt  <= '0;
                csum      <= '0;
            end

            if (po_flag) begin
                case (state)
                    S_OP: begin
                        cmd_wr <= (rx_data == OP_WR);
                        csum   <= rx_data;
                    end
                    S_ADDR: begin
                        cmd_addr <= (cmd_addr << 8) | ADDR_WIDTH'(rx_data);
                        csum     <= csum ^ rx_data;
                        byte_cnt <= last_addr ? '0 : byte_cnt + 1'b1;
                    end
                    S_DATA: begin
                        cmd_wdata <= (cmd_wdata << 8) | DATA_WIDTH'(rx_data);
                        csum      <= csum ^ rx_data;
                        byte_cnt  <= last_data ? '0 : byte_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser; frames adapt to whether CMD_PARSER_CSUM_EN is defined.
module tb_uart_cmd_parser;

    localparam int TO = 40;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [7:0]  rx_data;
    logic        po_flag;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [23:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        frame_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int xfer_cnt = 0;
    int err_cnt  = 0;
    int xfer_base;
    int err_base;
    logic        cap_wr;
    logic [23:0] cap_addr;
    logic [15:0] cap_wdata;

    logic [7:0] wr_frame [0:7];
    logic [7:0] bad_frame [0:7];
    logic [7:0] rd_frame [0:7];
    int wr_len;
    int rd_len;

    uart_cmd_parser #(.TIMEOUT_CYC(TO)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx_data   (rx_data),
        .po_flag   (po_flag),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Scoreboard of accepted commands and error-pulse cycles.
    always @(posedge sys_clk) begin
        if (sys_rst_n && cmd_valid && cmd_ready) begin
            xfer_cnt  = xfer_cnt + 1;
            cap_wr    = cmd_wr;
            cap_addr  = cmd_addr;
            cap_wdata = cmd_wdata;
        end
        if (frame_err) err_cnt = err_cnt + 1;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rx_data = b;
        po_flag = 1'b1;
        @(posedge sys_clk);
        #1;
        po_flag = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic sendFrame(input logic [7:0] f [0:7], input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(f[i]);
            if (i != n - 1) idle(2);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic markBase();
        xfer_base = xfer_cnt;
        err_base  = err_cnt;
    endtask

    initial begin
        wr_frame  = '{8'h55, 8'hA5, 8'h01, 8'h02, 8'h03, 8'hBE, 8'hEF, 8'hF4};
        bad_frame = '{8'h55, 8'hA5, 8'h01, 8'h02, 8'h03, 8'hBE, 8'hEF, 8'h00};
        rd_frame  = '{8'h55, 8'h5A, 8'h00, 8'h10, 8'h20, 8'h6A, 8'h00, 8'h00};
`ifdef CMD_PARSER_CSUM_EN
        wr_len = 8;
        rd_len = 6;
`else
        wr_len = 7;
        rd_len = 5;
`endif
        sys_rst_n = 1'b0;
        po_flag   = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b0;
        idle(3);
        checkOutput("rst_valid", 32'(cmd_valid), 32'h0);
        checkOutput("rst_busy",  32'(busy),      32'h0);
        checkOutput("rst_err",   32'(frame_err), 32'h0);
        checkOutput("rst_addr",  32'(cmd_addr),  32'h0);
        checkOutput("rst_wdata", 32'(cmd_wdata), 32'h0);
        sys_rst_n = 1'b1;
        idle(2);

        $display("[TB] write frame, ready held high");
        cmd_ready = 1'b1;
        markBase();
        sendFrame(wr_frame, wr_len);
        checkOutput("t1_valid", 32'(cmd_valid), 32'h1);
        checkOutput("t1_wr",    32'(cmd_wr),    32'h1);
        checkOutput("t1_addr",  32'(cmd_addr),  32'h010203);
        checkOutput("t1_wdata", 32'(cmd_wdata), 32'hBEEF);
        idle(1);
        checkOutput("t1_valid_drop", 32'(cmd_valid), 32'h0);
        checkOutput("t1_xfers", 32'(xfer_cnt - xfer_base), 32'h1);
        checkOutput("t1_cap_addr", 32'(cap_addr), 32'h010203);
        checkOutput("t1_errs",  32'(err_cnt - err_base), 32'h0);
        checkOutput("t1_busy",  32'(busy), 32'h0);

        $display("[TB] read frame, stalled consumer, overrun byte");
        cmd_ready = 1'b0;
        markBase();
        sendFrame(rd_frame, rd_len);
        checkOutput("t2_valid", 32'(cmd_valid), 32'h1);
        checkOutput("t2_wr",    32'(cmd_wr),    32'h0);
        checkOutput("t2_addr",  32'(cmd_addr),  32'h001020);
        checkOutput("t2_wdata", 32'(cmd_wdata), 32'h0);
        idle(20);
        applyStimulus(8'h55);
        idle(3);
        checkOutput("t2_overrun_err", 32'(err_cnt - err_base), 32'h1);
        checkOutput("t2_still_valid", 32'(cmd_valid), 32'h1);
        checkOutput("t2_still_addr",  32'(cmd_addr),  32'h001020);
        idle(25);
        checkOutput("t2_no_xfer_yet", 32'(xfer_cnt - xfer_base), 32'h0);
        cmd_ready = 1'b1;
        idle(1);
        checkOutput("t2_valid_drop", 32'(cmd_valid), 32'h0);
        checkOutput("t2_xfers",  32'(xfer_cnt - xfer_base), 32'h1);
        checkOutput("t2_cap_addr",  32'(cap_addr),  32'h001020);
        checkOutput("t2_cap_wdata", 32'(cap_wdata), 32'h0);
        checkOutput("t2_cap_wr",    32'(cap_wr),    32'h0);

`ifdef CMD_PARSER_CSUM_EN
        $display("[TB] checksum mismatch");
        markBase();
        sendFrame(bad_frame, 8);
        idle(3);
        checkOutput("t3_errs",  32'(err_cnt - err_base),   32'h1);
        checkOutput("t3_xfers", 32'(xfer_cnt - xfer_base), 32'h0);
        checkOutput("t3_busy",  32'(busy), 32'h0);
`endif

        $display("[TB] junk bytes and bad opcode");
        markBase();
        applyStimulus(8'h12);
        idle(2);
        applyStimulus(8'h34);
        idle(2);
        checkOutput("t4_junk_busy", 32'(busy), 32'h0);
        checkOutput("t4_junk_errs", 32'(err_cnt - err_base), 32'h0);
        applyStimulus(8'h55);
        checkOutput("t4_hdr_busy", 32'(busy), 32'h1);
        idle(2);
        applyStimulus(8'h77);
        idle(3);
        checkOutput("t4_op_errs", 32'(err_cnt - err_base), 32'h1);
        checkOutput("t4_op_busy", 32'(busy), 32'h0);
        sendFrame(wr_frame, wr_len);
        idle(1);
        checkOutput("t4_xfers",     32'(xfer_cnt - xfer_base), 32'h1);
        checkOutput("t4_cap_addr",  32'(cap_addr),  32'h010203);
        checkOutput("t4_cap_wdata", 32'(cap_wdata), 32'hBEEF);

        $display("[TB] inter-byte timeout");
        markBase();
        applyStimulus(8'h55);
        idle(2);
        applyStimulus(8'hA5);
        idle(2);
        applyStimulus(8'h01);
        idle(TO - 10);
        checkOutput("t5_busy_before", 32'(busy), 32'h1);
        checkOutput("t5_err_before",  32'(err_cnt - err_base), 32'h0);
        idle(15);
        checkOutput("t5_to_errs", 32'(err_cnt - err_base), 32'h1);
        checkOutput("t5_to_busy", 32'(busy), 32'h0);

        $display("[TB] reset mid-frame");
        markBase();
        sendFrame(wr_frame, 4);
        sys_rst_n = 1'b0;
        idle(2);
        checkOutput("t5_rst_busy",  32'(busy),     32'h0);
        checkOutput("t5_rst_addr",  32'(cmd_addr), 32'h0);
        checkOutput("t5_rst_wr",    32'(cmd_wr),   32'h0);
        checkOutput("t5_rst_valid", 32'(cmd_valid), 32'h0);
        sys_rst_n = 1'b1;
        idle(2);
        checkOutput("t5_rst_xfers", 32'(xfer_cnt - xfer_base), 32'h0);
        sendFrame(wr_frame, wr_len);
        checkOutput("t5_resend_addr",  32'(cmd_addr),  32'h010203);
        checkOutput("t5_resend_wdata", 32'(cmd_wdata), 32'hBEEF);
        idle(1);
        checkOutput("t5_resend_xfers", 32'(xfer_cnt - xfer_base), 32'h1);
        checkOutput("t5_resend_errs",  32'(err_cnt - err_base),   32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
